multicycle_sequencer: RTL

Parametrised multi-cycle instruction sequencer for the Pillar core; the next generation of the fixed 32-bit fetch-stage controller. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, skipping stages the decoded instruction does not need. It talks to memory over a req/ack handshake with arbitrary wait states and a bus timeout. It owns the instruction register and drives the PC-advance, ALU-latch and register-file write strobes.

---
 rtl/multicycle_sequencer_if.sv | 16 +
 rtl/multicycle_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer_if.sv
// Memory handshake bundle between the multicycle sequencer (master) and memory (slave).
// The request is held with stable address and data until ack is seen.
interface multicycle_sequencer_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with stage skipping,
// req/ack memory handshake with a wait-state timeout that parks the core in FAULT.
module multicycle_sequencer #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_i,
  output logic [2:0]         stage_o,
  multicycle_sequencer_if.master mem,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               pc_advance_o,
  output logic [XLEN-1:0]    ir_o,
  input  logic               dec_is_load_i,
  input  logic               dec_is_store_i,
  input  logic               dec_wb_i,
  input  logic [XLEN-1:0]    alu_result_i,
  input  logic [XLEN-1:0]    store_data_i,
  output logic               alu_readin_a_o,
  output logic               alu_readin_b_o,
  output logic               rf_we_o,
  output logic [XLEN-1:0]    rf_wdata_o,
  output logic               retire_o,
  output logic               fault_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  state_t            state;
  state_t            state_nxt;
  state_t            retire_nxt;
  logic [XLEN-1:0]   ir;
  logic [ADDR_W-1:0] addr_r;
  logic [XLEN-1:0]   wb_r;
  logic [XLEN-1:0]   sd_r;
  logic              ld_r;
  logic              st_r;
  logic [CW-1:0]     wait_cnt;
  logic              mem_phase;
  logic              timeout;

  assign mem_phase  = (state == S_FETCH) || (state == S_MEM);
  assign timeout    = (WAIT_MAX != 0) && (wait_cnt == CW'(WAIT_MAX)) && !mem.ack;
  assign retire_nxt = run_i ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run_i) state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem.ack)      state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (dec_is_load_i || dec_is_store_i) state_nxt = S_MEM;
        else if (dec_wb_i)                   state_nxt = S_WB;
        else                                 state_nxt = retire_nxt;
      end
      S_MEM: begin
        if (mem.ack)      state_nxt = ld_r ? S_WB : retire_nxt;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_WB:     state_nxt = retire_nxt;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Every cycle without ack is a wait cycle; leaving the request phase clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  wait_cnt <= '0;
    else if (mem_phase && !mem.ack) wait_cnt <= wait_cnt + 1'b1;
    else                         wait_cnt <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir     <= '0;
      addr_r <= '0;
      wb_r   <= '0;
      sd_r   <= '0;
      ld_r   <= 1'b0;
      st_r   <= 1'b0;
    end else begin
      if (state == S_FETCH && mem.ack) ir <= mem.rdata;
      if (state == S_EXEC) begin
        addr_r <= alu_result_i[ADDR_W-1:0];
        wb_r   <= alu_result_i;
        sd_r   <= store_data_i;
        ld_r   <= dec_is_load_i;
        st_r   <= dec_is_store_i;
      end
      if (state == S_MEM && mem.ack && ld_r) wb_r <= mem.rdata;
    end
  end

  // Retire lands in the instruction's last cycle, so it sees the EXEC flags and the MEM ack.
  always_comb begin
    mem.req        = 1'b0;
    mem.we         = 1'b0;
    mem.addr       = '0;
    mem.wdata      = '0;
    alu_readin_a_o = 1'b0;
    alu_readin_b_o = 1'b0;
    rf_we_o        = 1'b0;
    rf_wdata_o     = '0;
    retire_o       = 1'b0;
    fault_o        = 1'b0;
    case (state)
      S_FETCH: begin
        mem.req  = 1'b1;
        mem.addr = pc_i;
      end
      S_DECODE: begin
        alu_readin_a_o = 1'b1;
        alu_readin_b_o = 1'b1;
      end
      S_EXEC:   retire_o = !(dec_is_load_i || dec_is_store_i || dec_wb_i);
      S_MEM: begin
        mem.req  = 1'b1;
        mem.addr = addr_r;
        mem.we   = st_r && !ld_r;
        if (st_r && !ld_r) mem.wdata = sd_r;
        retire_o = mem.ack && !ld_r;
      end
      S_WB: begin
        rf_we_o    = 1'b1;
        rf_wdata_o = wb_r;
        retire_o   = 1'b1;
      end
      S_FAULT:  fault_o = 1'b1;
      default:  ;
    endcase
  end

  assign pc_advance_o = retire_o;
  assign stage_o      = state;
  assign ir_o         = ir;

endmodule
